frv_pipeline_writeback: RTL and testbench
=========================================

FRV_PIPELINE_WRITEBACK -- requirements
Module: frv_pipeline_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (XL = XLEN-1).
REQ-002 SHALL have parameter OP, default 4, micro-op MSB index; FU, default 6, functional-unit MSB index.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports g_clk in 1 clock; g_reset in 1 synchronous active-high reset.
REQ-005 SHALL have ports flush in 1 discard stage contents; s4_valid in 1; s4_busy out 1 stall to memory stage.
REQ-006 SHALL have ports s4_rd in 5; s4_opr_a in XLEN; s4_opr_b in XLEN (LSU: address); s4_uop in OP+1; s4_fu in FU+1 one-hot (0 ALU, 1 MUL, 2 LSU, 3 CFU, 4 CSR, 5 CRY, 6 SME); s4_trap in 1; s4_size in 2; s4_instr in 32.
REQ-007 SHALL have ports dmem_req in 1; dmem_gnt in 1 (request observation); dmem_recv in 1 response strobe; dmem_error in 1; dmem_rdata in XLEN.
REQ-008 SHALL have ports gpr_wen out 1; gpr_rd out 5; gpr_wdata out XLEN; trap_cpu out 1; trap_cause out 6; instr_ret out 1; fwd_s4_rd out 5; fwd_s4_wdata out XLEN; fwd_s4_load out 1 (load not yet completed).

Function
REQ-009 LSU uop decode SHALL be: uop[4] load, uop[3] store, uop[2:1] width (01 byte, 10 half, 11 word), uop[0] signed.
REQ-010 Response tracker SHALL be an FSM with states IDLE, PEND (one request outstanding), HELD (response buffered), DROP (outstanding response to discard).
REQ-011 IDLE->PEND on dmem_req&&dmem_gnt; PEND->IDLE on dmem_recv consumed same cycle by an LSU instr in stage; PEND->HELD on dmem_recv with no consuming LSU instr; HELD->IDLE when LSU instr retires.
REQ-012 On flush: PEND->DROP; HELD->IDLE; DROP stays; IDLE stays (or ->PEND if grant in same cycle).
REQ-013 DROP->IDLE on dmem_recv; response data/error discarded; DROP->PEND if dmem_recv and new grant coincide.
REQ-014 Holding register SHALL capture dmem_rdata and dmem_error on dmem_recv in PEND; dmem_recv in HELD/IDLE is a protocol violation (bench assertion).
REQ-015 s4_busy SHALL = s4_valid && s4_fu[2] && !(state==HELD) && !(state==PEND && dmem_recv) && !s4_trap.
REQ-016 instr_ret SHALL = s4_valid && !s4_busy && !flush, combinational, single cycle per instruction.
REQ-017 Load data SHALL select byte lane s4_opr_b[1:0] / half lane s4_opr_b[1] / full word, then sign-extend if uop[0] else zero-extend.
REQ-018 Response source SHALL be held register in HELD, else live dmem_rdata/dmem_error.
REQ-019 gpr_wen SHALL = instr_ret && !trap_cpu && s4_rd!=0 && (non-LSU FU, or LSU load); stores never write.
REQ-020 gpr_wdata SHALL be formatted load data for loads, else s4_opr_a; gpr_rd = s4_rd.
REQ-021 trap_cpu SHALL = instr_ret && (s4_trap || LSU response error); cause: s4_trap -> {1'b0,s4_rd}; load error -> 5; store error -> 7; s4_trap has priority.
REQ-022 fwd_s4_rd = s4_rd; fwd_s4_wdata = gpr_wdata; fwd_s4_load = s4_valid && s4_fu[2] && uop[4] && s4_busy.
REQ-023 Misaligned LSU traps arrive via s4_trap and SHALL retire without waiting for a response.

Reset
REQ-024 On g_reset: FSM IDLE, holding register 0, outstanding response forgotten; all outputs 0 while s4_valid=0.
REQ-025 Reset mid-PEND SHALL ignore the subsequent dmem_recv (bench does not drive it after reset).

Verification
REQ-026 ALU: s4_valid, fu=ALU, rd=5, opr_a=0x1234 -> same cycle gpr_wen=1, gpr_rd=5, gpr_wdata=0x1234, instr_ret=1.
REQ-027 LB signed, addr 0x...3, grant then recv 2 cycles later rdata=0x80FFFFFF -> s4_busy=1 for 2 cycles, then gpr_wdata=0xFFFFFF80.
REQ-028 LHU addr 0x...2, recv arrives before instr reaches stage (HELD), rdata=0xBEEF0000 -> retires first valid cycle, gpr_wdata=0x0000BEEF.
REQ-029 Store with dmem_error=1 -> trap_cpu=1, trap_cause=7, gpr_wen=0.
REQ-030 Flush in PEND, later recv rdata=0xDEAD -> dropped; next load receives its own response, FSM returns to IDLE.

Source files
------------

// File: rtl/frv_pipeline_writeback.sv
// Writeback stage: retires instructions, completes loads/stores against the data
// memory response channel, and raises traps for faulting instructions.
module frv_pipeline_writeback #(
    parameter int XLEN = 32,
    parameter int OP   = 4,
    parameter int FU   = 6
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            s4_valid,
    output logic            s4_busy,
    input  logic [4:0]      s4_rd,
    input  logic [XLEN-1:0] s4_opr_a,
    input  logic [XLEN-1:0] s4_opr_b,
    input  logic [OP:0]     s4_uop,
    input  logic [FU:0]     s4_fu,
    input  logic            s4_trap,
    input  logic [1:0]      s4_size,
    input  logic [31:0]     s4_instr,
    input  logic            dmem_req,
    input  logic            dmem_gnt,
    input  logic            dmem_recv,
    input  logic            dmem_error,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            gpr_wen,
    output logic [4:0]      gpr_rd,
    output logic [XLEN-1:0] gpr_wdata,
    output logic            trap_cpu,
    output logic [5:0]      trap_cause,
    output logic            instr_ret,
    output logic [4:0]      fwd_s4_rd,
    output logic [XLEN-1:0] fwd_s4_wdata,
    output logic            fwd_s4_load
);

    typedef enum logic [1:0] {IDLE, PEND, HELD, DROP} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] hold_data_reg;
    logic            hold_err_reg;

    logic            grant;
    logic            lsu_instr;
    logic            is_load;
    logic            consume_recv;
    logic            lsu_retire;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic [7:0]      lane_byte [4];
    logic [15:0]     lane_half [2];
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    wire unused_inputs = ^{s4_instr, s4_size, s4_opr_b, s4_uop, s4_fu};

    assign grant        = dmem_req && dmem_gnt;
    assign lsu_instr    = s4_valid && s4_fu[2];
    assign is_load      = s4_uop[4];
    assign consume_recv = lsu_instr && !s4_trap && !flush;
    assign lsu_retire   = instr_ret && s4_fu[2] && !s4_trap;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            hold_data_reg <= '0;
            hold_err_reg  <= 1'b0;
        end else if (state_reg == PEND && dmem_recv) begin
            hold_data_reg <= dmem_rdata;
            hold_err_reg  <= dmem_error;
        end
    end

    // A new grant may overlap the cycle in which the previous response completes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant) state_next = PEND;
            PEND: begin
                if (flush) begin
                    if (dmem_recv) state_next = grant ? PEND : IDLE;
                    else           state_next = DROP;
                end else if (dmem_recv) begin
                    if (consume_recv) state_next = grant ? PEND : IDLE;
                    else              state_next = HELD;
                end
            end
            HELD: if (flush || lsu_retire) state_next = grant ? PEND : IDLE;
            DROP: if (dmem_recv) state_next = grant ? PEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign resp_data = (state_reg == HELD) ? hold_data_reg : dmem_rdata;
    assign resp_err  = (state_reg == HELD) ? hold_err_reg  : dmem_error;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign lane_byte[gi] = resp_data[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign lane_half[gi] = resp_data[16*gi +: 16];
    end

    assign load_byte = lane_byte[s4_opr_b[1:0]];
    assign load_half = lane_half[s4_opr_b[1]];

    always_comb begin
        load_data = resp_data;
        case (s4_uop[2:1])
            2'b01:   load_data = {{(XLEN-8){s4_uop[0] && load_byte[7]}}, load_byte};
            2'b10:   load_data = {{(XLEN-16){s4_uop[0] && load_half[15]}}, load_half};
            default: load_data = resp_data;
        endcase
    end

    always_comb begin
        s4_busy      = lsu_instr
                     && !(state_reg == HELD)
                     && !(state_reg == PEND && dmem_recv)
                     && !s4_trap;
        instr_ret    = s4_valid && !s4_busy && !flush;
        trap_cpu     = instr_ret && (s4_trap || (s4_fu[2] && resp_err));
        trap_cause   = 6'd0;
        if (trap_cpu) begin
            if (s4_trap)      trap_cause = {1'b0, s4_rd};
            else if (is_load) trap_cause = 6'd5;
            else              trap_cause = 6'd7;
        end
        gpr_wen      = instr_ret && !trap_cpu && (s4_rd != 5'd0)
                     && (!s4_fu[2] || is_load);
        gpr_rd       = s4_valid ? s4_rd : 5'd0;
        gpr_wdata    = '0;
        if (s4_valid) gpr_wdata = (s4_fu[2] && is_load) ? load_data : s4_opr_a;
        fwd_s4_rd    = gpr_rd;
        fwd_s4_wdata = gpr_wdata;
        fwd_s4_load  = lsu_instr && is_load && s4_busy;
    end

endmodule

// File: tb/tb_frv_pipeline_writeback.sv
// Directed bench for the writeback stage: ALU retire, loads through each
// response-tracker path, store/load errors, pipeline traps and flush-drop.
module tb_frv_pipeline_writeback;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        flush;
    logic        s4_valid;
    logic        s4_busy;
    logic [4:0]  s4_rd;
    logic [31:0] s4_opr_a;
    logic [31:0] s4_opr_b;
    logic [4:0]  s4_uop;
    logic [6:0]  s4_fu;
    logic        s4_trap;
    logic [1:0]  s4_size;
    logic [31:0] s4_instr;
    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_recv;
    logic        dmem_error;
    logic [31:0] dmem_rdata;
    logic        gpr_wen;
    logic [4:0]  gpr_rd;
    logic [31:0] gpr_wdata;
    logic        trap_cpu;
    logic [5:0]  trap_cause;
    logic        instr_ret;
    logic [4:0]  fwd_s4_rd;
    logic [31:0] fwd_s4_wdata;
    logic        fwd_s4_load;

    int checks = 0;
    int passed = 0;

    localparam logic [6:0] FU_ALU = 7'b0000001;
    localparam logic [6:0] FU_LSU = 7'b0000100;
    localparam logic [4:0] UOP_LB  = 5'b10011;
    localparam logic [4:0] UOP_LH  = 5'b10101;
    localparam logic [4:0] UOP_LHU = 5'b10100;
    localparam logic [4:0] UOP_LW  = 5'b10110;
    localparam logic [4:0] UOP_SW  = 5'b01110;

    frv_pipeline_writeback dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .s4_valid(s4_valid),
        .s4_busy(s4_busy), .s4_rd(s4_rd), .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b),
        .s4_uop(s4_uop), .s4_fu(s4_fu), .s4_trap(s4_trap), .s4_size(s4_size),
        .s4_instr(s4_instr), .dmem_req(dmem_req), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata), .trap_cpu(trap_cpu),
        .trap_cause(trap_cause), .instr_ret(instr_ret), .fwd_s4_rd(fwd_s4_rd),
        .fwd_s4_wdata(fwd_s4_wdata), .fwd_s4_load(fwd_s4_load)
    );

    always #5 g_clk = ~g_clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
    task automatic next_cycle();
        @(posedge g_clk);
        #1;
        flush = 0; s4_valid = 0; s4_rd = 0; s4_opr_a = 0; s4_opr_b = 0; s4_uop = 0;
        s4_fu = 0; s4_trap = 0; s4_size = 0; s4_instr = 0; dmem_req = 0; dmem_gnt = 0;
        dmem_recv = 0; dmem_error = 0; dmem_rdata = 0;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        g_reset = 1;
        next_cycle();
        s4_opr_a = 32'h5555_AAAA;
        settle();
        checks++; if (gpr_wen !== 1'b0) $display("FAIL reset_wen got %0h want 0", gpr_wen); else passed++;
        checks++; if (instr_ret !== 1'b0) $display("FAIL reset_ret got %0h want 0", instr_ret); else passed++;
        checks++; if (s4_busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", s4_busy); else passed++;
        checks++; if (trap_cpu !== 1'b0) $display("FAIL reset_trap got %0h want 0", trap_cpu); else passed++;
        checks++; if (gpr_wdata !== 32'h0) $display("FAIL reset_wdata got %08h want 0", gpr_wdata); else passed++;
        checks++; if (fwd_s4_load !== 1'b0) $display("FAIL reset_fwdload got %0h want 0", fwd_s4_load); else passed++;
        next_cycle();
        g_reset = 0;
        $display("reset: done");
    endtask

    task automatic test_alu();
        next_cycle();
        s4_valid = 1; s4_fu = FU_ALU; s4_rd = 5; s4_opr_a = 32'h1234;
        settle();
        checks++; if (gpr_wen !== 1'b1) $display("FAIL alu_wen got %0h want 1", gpr_wen); else passed++;
        checks++; if (gpr_rd !== 5'd5) $display("FAIL alu_rd got %0d want 5", gpr_rd); else passed++;
        checks++; if (gpr_wdata !== 32'h1234) $display("FAIL alu_wdata got %08h want 00001234", gpr_wdata); else passed++;
        checks++; if (instr_ret !== 1'b1) $display("FAIL alu_ret got %0h want 1", instr_ret); else passed++;
        checks++; if (fwd_s4_wdata !== 32'h1234) $display("FAIL alu_fwd got %08h want 00001234", fwd_s4_wdata); else passed++;
        $display("alu: rd=%0d wdata=%08h", gpr_rd, gpr_wdata);
    endtask

    task automatic test_load_byte_signed();
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LB; s4_rd = 7; s4_opr_b = 32'h1003;
        dmem_req = 1; dmem_gnt = 1;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL lb_busy0 got %0h want 1", s4_busy); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LB; s4_rd = 7; s4_opr_b = 32'h1003;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL lb_busy1 got %0h want 1", s4_busy); else passed++;
        checks++; if (fwd_s4_load !== 1'b1) $display("FAIL lb_fwdload got %0h want 1", fwd_s4_load); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LB; s4_rd = 7; s4_opr_b = 32'h1003;
        dmem_recv = 1; dmem_rdata = 32'h80FF_FFFF;
        settle();
        checks++; if (s4_busy !== 1'b0) $display("FAIL lb_busy2 got %0h want 0", s4_busy); else passed++;
        checks++; if (gpr_wdata !== 32'hFFFF_FF80) $display("FAIL lb_wdata got %08h want ffffff80", gpr_wdata); else passed++;
        checks++; if (gpr_wen !== 1'b1) $display("FAIL lb_wen got %0h want 1", gpr_wen); else passed++;
        checks++; if (fwd_s4_load !== 1'b0) $display("FAIL lb_fwdload_done got %0h want 0", fwd_s4_load); else passed++;
        $display("lb: wdata=%08h", gpr_wdata);
    endtask

    task automatic test_load_half_held();
        next_cycle();
        dmem_req = 1; dmem_gnt = 1;
        next_cycle();
        dmem_recv = 1; dmem_rdata = 32'hBEEF_0000;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LHU; s4_rd = 9; s4_opr_b = 32'h2002;
        dmem_rdata = 32'h1234_5678;
        settle();
        checks++; if (s4_busy !== 1'b0) $display("FAIL lhu_busy got %0h want 0", s4_busy); else passed++;
        checks++; if (instr_ret !== 1'b1) $display("FAIL lhu_ret got %0h want 1", instr_ret); else passed++;
        checks++; if (gpr_wdata !== 32'h0000_BEEF) $display("FAIL lhu_wdata got %08h want 0000beef", gpr_wdata); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 9;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL lhu_idle_after got %0h want 1", s4_busy); else passed++;
        $display("lhu: held response consumed");
    endtask

    task automatic test_errors_and_traps();
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_SW; s4_rd = 3; dmem_req = 1; dmem_gnt = 1;
        settle();
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_SW; s4_rd = 3;
        dmem_recv = 1; dmem_error = 1;
        settle();
        checks++; if (trap_cpu !== 1'b1) $display("FAIL st_err_trap got %0h want 1", trap_cpu); else passed++;
        checks++; if (trap_cause !== 6'd7) $display("FAIL st_err_cause got %0d want 7", trap_cause); else passed++;
        checks++; if (gpr_wen !== 1'b0) $display("FAIL st_err_wen got %0h want 0", gpr_wen); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 6; dmem_req = 1; dmem_gnt = 1;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 6;
        dmem_recv = 1; dmem_error = 1; dmem_rdata = 32'h1111_2222;
        settle();
        checks++; if (trap_cause !== 6'd5) $display("FAIL ld_err_cause got %0d want 5", trap_cause); else passed++;
        checks++; if (gpr_wen !== 1'b0) $display("FAIL ld_err_wen got %0h want 0", gpr_wen); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 4; s4_trap = 1; s4_opr_b = 32'h3001;
        settle();
        checks++; if (s4_busy !== 1'b0) $display("FAIL mis_busy got %0h want 0", s4_busy); else passed++;
        checks++; if (trap_cpu !== 1'b1) $display("FAIL mis_trap got %0h want 1", trap_cpu); else passed++;
        checks++; if (trap_cause !== 6'd4) $display("FAIL mis_cause got %0d want 4", trap_cause); else passed++;
        $display("errors: store/load/misaligned traps checked");
    endtask

    task automatic test_flush_drop();
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 8; dmem_req = 1; dmem_gnt = 1;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 8; flush = 1;
        settle();
        checks++; if (instr_ret !== 1'b0) $display("FAIL flush_ret got %0h want 0", instr_ret); else passed++;
        next_cycle();
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 10; dmem_req = 1; dmem_gnt = 1;
        dmem_recv = 1; dmem_rdata = 32'h0000_DEAD;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL drop_busy got %0h want 1", s4_busy); else passed++;
        checks++; if (gpr_wen !== 1'b0) $display("FAIL drop_wen got %0h want 0", gpr_wen); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 10;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL drop_pend_busy got %0h want 1", s4_busy); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 10;
        dmem_recv = 1; dmem_rdata = 32'hCAFE_F00D;
        settle();
        checks++; if (gpr_wdata !== 32'hCAFE_F00D) $display("FAIL drop_own_wdata got %08h want cafef00d", gpr_wdata); else passed++;
        checks++; if (gpr_wen !== 1'b1) $display("FAIL drop_own_wen got %0h want 1", gpr_wen); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LW; s4_rd = 10;
        settle();
        checks++; if (s4_busy !== 1'b1) $display("FAIL drop_idle_after got %0h want 1", s4_busy); else passed++;
        $display("flush: stale response dropped");
    endtask

    task automatic test_back_to_back();
        next_cycle();
        s4_valid = 1; s4_fu = FU_ALU; s4_rd = 0; s4_opr_a = 32'h7777;
        settle();
        checks++; if (gpr_wen !== 1'b0) $display("FAIL b2b_x0_wen got %0h want 0", gpr_wen); else passed++;
        checks++; if (instr_ret !== 1'b1) $display("FAIL b2b_x0_ret got %0h want 1", instr_ret); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LH; s4_rd = 12; s4_opr_b = 32'h4002;
        dmem_req = 1; dmem_gnt = 1;
        next_cycle();
        s4_valid = 1; s4_fu = FU_LSU; s4_uop = UOP_LH; s4_rd = 12; s4_opr_b = 32'h4002;
        dmem_recv = 1; dmem_rdata = 32'h8001_4321;
        settle();
        checks++; if (gpr_wdata !== 32'hFFFF_8001) $display("FAIL lh_wdata got %08h want ffff8001", gpr_wdata); else passed++;
        next_cycle();
        s4_valid = 1; s4_fu = FU_ALU; s4_rd = 13; s4_opr_a = 32'hA5A5_0001;
        settle();
        checks++; if (gpr_wdata !== 32'hA5A5_0001) $display("FAIL b2b_alu_wdata got %08h want a5a50001", gpr_wdata); else passed++;
        checks++; if (fwd_s4_rd !== 5'd13) $display("FAIL b2b_fwd_rd got %0d want 13", fwd_s4_rd); else passed++;
        $display("back_to_back: done");
    endtask

    initial begin
        g_reset = 1;
        flush = 0; s4_valid = 0; s4_rd = 0; s4_opr_a = 0; s4_opr_b = 0; s4_uop = 0;
        s4_fu = 0; s4_trap = 0; s4_size = 0; s4_instr = 0; dmem_req = 0; dmem_gnt = 0;
        dmem_recv = 0; dmem_error = 0; dmem_rdata = 0;
        test_reset();
        test_alu();
        test_load_byte_signed();
        test_load_half_held();
        test_errors_and_traps();
        test_flush_drop();
        test_back_to_back();
        next_cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
